// File: rtl/alu_mdu_sequencer_if.sv
// Decoder/MDU bundle between the core controller and the ALU/MDU sequencer.
// The controller is the master. The sequencer is the slave.
interface alu_mdu_sequencer_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              opb5;
    logic              funct7b5;
    logic              funct7b0;
    logic [2:0]        funct3;
    logic [1:0]        ALUOp;
    logic              start;
    logic [XLEN-1:0]   srcA;
    logic [XLEN-1:0]   srcB;
    logic [CTRL_W-1:0] ALUControl;
    logic              is_mdu;
    logic              mdu_busy;
    logic              mdu_done;
    logic [XLEN-1:0]   mdu_result;

    modport master (
        output opb5, funct7b5, funct7b0, funct3, ALUOp, start, srcA, srcB,
        input  ALUControl, is_mdu, mdu_busy, mdu_done, mdu_result
    );

    modport slave (
        input  opb5, funct7b5, funct7b0, funct3, ALUOp, start, srcA, srcB,
        output ALUControl, is_mdu, mdu_busy, mdu_done, mdu_result
    );
endinterface

// File: rtl/alu_mdu_sequencer.sv
// ALU control decoder plus an iterative RV-M multiply/divide unit.
// The MDU runs one radix-2 step per cycle on operand magnitudes and fixes the sign at the end.
module alu_mdu_sequencer #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_mdu_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic [3:0]        w_ctl;
    logic              w_is_mdu;

    always_comb begin
        w_is_mdu = (bus.ALUOp == 2'b10) & bus.opb5 & bus.funct7b0;
        w_ctl    = 4'b0000;
        case (bus.ALUOp)
            2'b00: w_ctl = 4'b0000;
            2'b01: w_ctl = 4'b0001;
            2'b11: w_ctl = 4'b1010;
            default: begin
                case (bus.funct3)
                    3'b000:  w_ctl = (bus.funct7b5 & bus.opb5) ? 4'b0001 : 4'b0000;
                    3'b001:  w_ctl = 4'b0110;
                    3'b010:  w_ctl = 4'b0101;
                    3'b011:  w_ctl = 4'b1001;
                    3'b100:  w_ctl = 4'b0100;
                    3'b101:  w_ctl = bus.funct7b5 ? 4'b1000 : 4'b0111;
                    3'b110:  w_ctl = 4'b0011;
                    default: w_ctl = 4'b0010;
                endcase
            end
        endcase
        if (w_is_mdu) w_ctl = 4'b1111;
    end

    assign bus.ALUControl = CTRL_W'(w_ctl);
    assign bus.is_mdu     = w_is_mdu;

    // Operand signedness by funct3. MUL is treated as signed; its low half is sign-agnostic.
    logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_div, w_divz, w_ovf, w_accept, w_neg_l;
    logic [XLEN-1:0]   w_spec_res;

    assign w_a_sgn  = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    assign w_b_sgn  = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    assign w_a_neg  = w_a_sgn & bus.srcA[XLEN-1];
    assign w_b_neg  = w_b_sgn & bus.srcB[XLEN-1];
    assign w_a_mag  = w_a_neg ? -bus.srcA : bus.srcA;
    assign w_b_mag  = w_b_neg ? -bus.srcB : bus.srcB;
    assign w_div    = bus.funct3[2];
    assign w_divz   = w_div & (bus.srcB == '0);
    assign w_ovf    = w_div & ~bus.funct3[0] & (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.srcB);
    assign w_accept = bus.start & w_is_mdu & (r_state != S_RUN);
    // A remainder follows the dividend sign. Everything else follows the sign of the product/quotient.
    assign w_neg_l  = (w_div & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    always_comb begin
        if (w_divz)
            w_spec_res = bus.funct3[1] ? bus.srcA : '1;
        else
            w_spec_res = bus.funct3[1] ? '0 : bus.srcA;
    end

    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_sub;
    logic [XLEN-1:0]   w_hi_nx, w_lo_nx;

    // mul: {hi,lo} = partial product : multiplier. div: hi = partial remainder, lo = dividend -> quotient.
    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        w_sum   = '0;
        w_sub   = '0;
        if (!r_f3[2]) begin
            w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end else begin
            w_sub = {1'b0, r_hi, r_lo[XLEN-1]} - {2'b00, r_b};
            if (!w_sub[XLEN+1]) begin
                w_hi_nx = w_sub[XLEN-1:0];
                w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nx = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_fin;

    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo    = r_neg ? -w_lo_nx : w_lo_nx;
    assign w_rem    = r_neg ? -w_hi_nx : w_hi_nx;

    always_comb begin
        if (r_f3[2])
            w_fin = r_f3[1] ? w_rem : w_quo;
        else if (r_f3[1:0] == 2'b00)
            w_fin = w_prod_s[XLEN-1:0];
        else
            w_fin = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_fin;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_f3  <= bus.funct3;
                        r_neg <= w_neg_l;
                        r_cnt <= '0;
                        r_hi  <= '0;
                        r_lo  <= w_div ? w_a_mag : w_b_mag;
                        r_b   <= w_div ? w_b_mag : w_a_mag;
                        if (w_divz | w_ovf) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_spec_res;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.mdu_busy   = r_busy;
    assign bus.mdu_done   = r_done;
    assign bus.mdu_result = r_result;
endmodule
